// File: rtl/io_output_collector.sv
// Host side of the CPU I/O link: issues the startIO pulse, captures output words into a
// first-word-fall-through FIFO and declares end of run after an output-idle timeout.
module io_output_collector #(
  parameter int WIDTH       = 24,
  parameter int DEPTH       = 16,
  parameter int PTRWIDTH    = 4,
  parameter int IDLETIMEOUT = 1024,
  parameter int COUNTWIDTH  = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                go,
  output logic                startIO,
  input  logic                outFlag,
  input  logic [WIDTH-1:0]    cpuOut,
  input  logic                readEnable,
  output logic [WIDTH-1:0]    readData,
  output logic                readValid,
  output logic [PTRWIDTH:0]   wordCount,
  output logic                busy,
  output logic                done,
  output logic                overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [PTRWIDTH:0]     FULL_COUNT = (PTRWIDTH+1)'(DEPTH);
  localparam logic [PTRWIDTH:0]     COUNT_ONE  = (PTRWIDTH+1)'(1);
  localparam logic [PTRWIDTH-1:0]   PTR_ONE    = PTRWIDTH'(1);
  localparam logic [COUNTWIDTH-1:0] IDLE_ONE   = COUNTWIDTH'(1);
  localparam logic [COUNTWIDTH-1:0] IDLE_LAST  = COUNTWIDTH'(IDLETIMEOUT - 1);

  state_t                r_state;
  logic                  r_go_prev;
  logic [COUNTWIDTH-1:0] r_idle_cnt;
  logic                  r_start_io;
  logic                  r_busy;
  logic                  r_done;

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [PTRWIDTH-1:0]   r_wr_ptr;
  logic [PTRWIDTH-1:0]   r_rd_ptr;
  logic [PTRWIDTH:0]     r_count;
  logic                  r_overflow;
  logic [WIDTH-1:0]      r_head;

  logic                  w_go_rise;
  logic                  w_clear;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_push_req;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [PTRWIDTH-1:0]   w_rd_next;
  logic [PTRWIDTH:0]     w_count_after_pop;

  assign w_go_rise  = go & ~r_go_prev;
  assign w_clear    = w_go_rise && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == FULL_COUNT);
  assign w_push_req = (r_state == S_RUN) && outFlag;
  assign w_pop      = readEnable && !w_empty && !w_clear;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  assign w_rd_next         = r_rd_ptr + (w_pop ? PTR_ONE : '0);
  assign w_count_after_pop = r_count - (w_pop ? COUNT_ONE : '0);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_go_prev  <= 1'b0;
      r_idle_cnt <= '0;
      r_start_io <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_go_prev <= go;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_go_rise) begin
            r_state    <= S_START;
            r_start_io <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
          end
        end
        S_START: begin
          r_state    <= S_RUN;
          r_start_io <= 1'b0;
          r_idle_cnt <= '0;
        end
        S_RUN: begin
          if (outFlag) begin
            r_idle_cnt <= '0;
          end else if (r_idle_cnt == IDLE_LAST) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_idle_cnt <= r_idle_cnt + IDLE_ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the storage array has no reset; only pointers and count define which words are live.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= cpuOut;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_head     <= '0;
    end else if (w_clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= w_rd_next;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + COUNT_ONE;
        2'b01:   r_count <= r_count - COUNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
      // Head register: the incoming word bypasses storage when it becomes the only entry.
      if (w_push && (w_count_after_pop == '0)) begin
        r_head <= cpuOut;
      end else if (w_pop && (r_count > COUNT_ONE)) begin
        r_head <= r_mem[w_rd_next];
      end
    end
  end

  assign startIO   = r_start_io;
  assign busy      = r_busy;
  assign done      = r_done;
  assign overflow  = r_overflow;
  assign readData  = r_head;
  assign readValid = !w_empty;
  assign wordCount = r_count;

endmodule

// File: doc/io_output_collector.md
Name: io_output_collector

Overview:
- Host-side counterpart of the processor's I/O interface.
- Issues the single-cycle startIO pulse that launches a program run, then captures every output word the CPU presents on out/outFlag.
- Buffers captured words in a first-word-fall-through FIFO for a downstream consumer (display or serial driver).
- Detects end of run by an output-idle timeout and reports status.

Parameters:
- WIDTH, 24, data word width; matches CPU out bus.
- DEPTH, 16, FIFO capacity in words; power of two.
- PTRWIDTH, 4, log2(DEPTH).
- IDLETIMEOUT, 1024, consecutive cycles without outFlag that end a run; minimum 2.
- COUNTWIDTH, 16, idle counter width; must hold IDLETIMEOUT.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- go  input  1  run request, level; synchronised externally; rising edge acts.
- startIO  output  1  one-cycle start pulse to CPU.
- outFlag  input  1  CPU output-valid qualifier, one word per high cycle.
- cpuOut  input  WIDTH  CPU output data, valid when outFlag high.
- readEnable  input  1  consumer pop request.
- readData  output  WIDTH  FIFO head word.
- readValid  output  1  FIFO non-empty.
- wordCount  output  PTRWIDTH+1  words currently stored, 0..DEPTH.
- busy  output  1  high in START or RUN.
- done  output  1  high in DONE.
- overflow  output  1  sticky: a word was dropped because the FIFO was full.

Behaviour:
- Reset (async, any state, mid-run included): state IDLE; startIO=0, busy=0, done=0, overflow=0, readValid=0, wordCount=0, readData=0; FIFO pointers and idle counter cleared.
- go edge detect: goPrev register, reset 0; goRise = go & ~goPrev.
- FSM states: IDLE, START, RUN, DONE.
- IDLE: on goRise -> START. The same edge clears the FIFO (pointers and count to 0) and clears overflow.
- START: startIO=1 for exactly this one cycle; idle counter set to 0; -> RUN unconditionally.
- RUN: if outFlag=1, counter <= 0. Otherwise counter increments; when counter == IDLETIMEOUT-1 while outFlag=0 -> DONE. DONE is therefore entered after exactly IDLETIMEOUT consecutive idle cycles.
- DONE: done=1. On goRise -> START, with the same FIFO and overflow clear as from IDLE.
- goRise in START or RUN is ignored.
- Capture: only in RUN. When outFlag=1, cpuOut is pushed.
- outFlag is ignored in IDLE, START and DONE.
- Capture latency: a word pushed at edge n appears on readData and raises readValid in cycle n+1 when the FIFO was empty.
- Pop: on readEnable=1 and readValid=1 the head advances. readEnable while empty is ignored; no underflow state.
- Pops are allowed in every state.
- Simultaneous push and pop:
  - Non-empty and not full: both occur; wordCount unchanged.
  - Full: both occur; no overflow.
  - Empty: push only; pop ignored.
- Push when full without pop: word dropped, overflow <= 1 (sticky until reset or the next run start); contents unchanged.
- Pointers wrap modulo DEPTH. wordCount is computed exactly, with no aliasing between full and empty.
- readData when empty: holds the last head value; it is not meaningful.
- A new run starting while words remain: remaining words are discarded.

Test Plan:
Bench parameters: DEPTH=4, IDLETIMEOUT=8.
- Reset, then go 0->1: startIO high exactly one cycle, busy=1 the next cycle; no further startIO while go stays high.
- In RUN, outFlag pulses with cpuOut=0x000011, 0x000022, 0x000033, then idle: readValid rises 1 cycle after the first push; wordCount=3; done asserts after 8 idle cycles following the 0x000033 push; pops return 0x11, 0x22, 0x33 in order, then readValid=0.
- Push 5 words with no pops: wordCount=4, overflow=1, and the stored words are the first four. A second go edge after DONE clears overflow and wordCount to 0.
- FIFO full (4 words), outFlag and readEnable in the same cycle with cpuOut=0xABCDEF: wordCount stays 4, overflow stays 0, 0xABCDEF is read last.
- Assert reset mid-RUN with 2 words stored: all outputs 0 immediately (async); after release the FSM is in IDLE and outFlag pulses are ignored until the next go edge.
- outFlag pulses in DONE and readEnable on an empty FIFO: no push, wordCount stays 0, readValid stays 0.
